pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters: AW=12 (address width); DEPTH=8 (return stack entries); RST_VEC=12'h000; INT_VEC=12'h004.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 PCEN_i  in  1  update enable from control unit; 0 holds all state.
REQ-005 PCoper_i  in  4  PC operation select from control unit.
REQ-006 jbs_i  in  1  jump-to-subroutine request.
REQ-007 ret_i  in  1  return-from-subroutine request.
REQ-008 reti_i  in  1  return-from-interrupt request.
REQ-009 int_i  in  1  interrupt entry request.
REQ-010 target_i  in  AW  absolute jump/branch/call target.
REQ-011 z_i, c_i  in  1 each  ALU zero and carry flags, registered by the datapath.
REQ-012 pc_o  out  AW  current program counter, i.e. the instruction fetch address.
REQ-013 isr_o  out  1  interrupt service in progress.
REQ-014 stk_full_o, stk_empty_o  out  1 each  return stack status, combinational from the stack depth counter.
REQ-015 stk_err_o  out  1  sticky stack overflow/underflow flag.

Function
REQ-016 With PCEN_i=0, pc_o, the stack, isr_o and stk_err_o hold their values regardless of other inputs.
REQ-017 With PCEN_i=1, exactly one action fires per cycle, chosen by fixed priority: int_i (only when isr_o=0), then reti_i, then ret_i, then jbs_i, then PCoper_i.
REQ-018 PCoper_i encoding:
- 0000: pc+1
- 0100: BZ, target_i if z_i=1 else pc+1
- 0101: BNZ, target_i if z_i=0 else pc+1
- 0110: BC, target_i if c_i=1 else pc+1
- 0111: BNC, target_i if c_i=0 else pc+1
- 1000: JMP, target_i
- any other code: pc+1
REQ-019 All PC arithmetic is modulo 2^AW; pc+1 from all-ones wraps to 0 with no flag raised.
REQ-020 jbs_i: push pc+1 onto the stack, increment depth, load pc with target_i; all updates in the same cycle.
REQ-021 ret_i: load pc with the top-of-stack entry and decrement depth.
REQ-022 Stack is LIFO with depth counter 0..DEPTH; stk_full_o=(depth==DEPTH); stk_empty_o=(depth==0).
REQ-023 jbs_i when full: push dropped, depth unchanged, stk_err_o set, pc still loads target_i.
REQ-024 ret_i when empty: depth unchanged, stk_err_o set, pc loads pc+1.
REQ-025 int_i with isr_o=0 has this effect:
- the single-entry register int_ret is loaded with the current pc (the interrupted instruction address, not pc+1)
- pc loads INT_VEC
- isr_o is set
- the stack is untouched
REQ-026 int_i while isr_o=1 is ignored (no nesting); the next-priority request is evaluated instead.
REQ-027 reti_i: pc loads int_ret and isr_o is cleared. With isr_o=0, reti_i behaves as pc+1 and sets stk_err_o.
REQ-028 Simultaneous jbs_i and ret_i: only ret_i acts, per REQ-017; no push occurs.
REQ-029 stk_err_o is cleared only by reset.
REQ-030 All outputs are registered except the stack status flags (REQ-014). Latency is one cycle: a request sampled at edge N is visible on pc_o after edge N.

Reset
REQ-031 rst low asynchronously forces these values, held while rst=0, including mid-call or mid-ISR:
- pc_o=RST_VEC
- depth=0 (stk_empty_o=1, stk_full_o=0)
- isr_o=0
- stk_err_o=0
- int_ret=RST_VEC
REQ-032 After rst deasserts, the first update occurs at the first rising edge with PCEN_i=1.
REQ-033 Stack entry contents are don't-care after reset; they are never observable without a prior push.

Verification
REQ-034 Sequential run: reset, PCEN_i=1, PCoper_i=0000 for 5 cycles -> pc_o=0,1,2,3,4,5. Then PCEN_i=0 for 3 cycles -> pc_o holds at 5.
REQ-035 Branches: pc=0x010, target_i=0x080:
- BZ with z_i=0 -> 0x011
- then BZ with z_i=1 -> 0x080
- then BNC with c_i=0 -> 0x080
- then JMP target_i=0xFFF, then 0000 -> 0xFFF, then wraps to 0x000
REQ-036 Call/return: pc=0x020, jbs_i with target_i=0x100 -> pc=0x100, depth=1. Three increments then ret_i -> pc=0x021, stk_empty_o=1, stk_err_o=0.
REQ-037 Stack overflow/underflow:
- 9 nested jbs_i -> stk_full_o=1 after the 8th; 9th sets stk_err_o=1, depth stays 8.
- 8 ret_i return the addresses in reverse order; a 9th ret_i -> pc=prev+1, stk_err_o still 1.
REQ-038 Interrupt: pc=0x050, int_i -> pc=0x004, isr_o=1. A second int_i with PCoper_i=0000 -> pc=0x005 (ignored). reti_i -> pc=0x050, isr_o=0. int_i with jbs_i together -> int_i wins, stack unchanged.
REQ-039 Reset mid-operation: depth=3, isr_o=1, pc=0x123; rst pulsed low between clock edges -> immediately pc_o=0, stk_empty_o=1, isr_o=0, stk_err_o=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter unit: sequential/branch/jump sequencing, an 8-deep return
// stack for subroutine calls, and a single-level interrupt return register.
module pc_unit #(
  parameter int             AW      = 12,
  parameter int             DEPTH   = 8,
  parameter logic [AW-1:0]  RST_VEC = '0,
  parameter logic [AW-1:0]  INT_VEC = AW'(4)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCEN_i,
  input  logic [3:0]    PCoper_i,
  input  logic          jbs_i,
  input  logic          ret_i,
  input  logic          reti_i,
  input  logic          int_i,
  input  logic [AW-1:0] target_i,
  input  logic          z_i,
  input  logic          c_i,
  output logic [AW-1:0] pc_o,
  output logic          isr_o,
  output logic          stk_full_o,
  output logic          stk_empty_o,
  output logic          stk_err_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_int_ret;
  logic [DW-1:0] r_depth;
  logic          r_isr;
  logic          r_err;
  logic [AW-1:0] r_stack [DEPTH];

  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_int_ret_nxt;
  logic [DW-1:0] w_depth_nxt;
  logic          w_isr_nxt;
  logic          w_err_nxt;
  logic          w_push;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;
  logic          w_full;
  logic          w_empty;

  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  // The write slot is the low bits of depth; it is never used when full.
  assign w_push_idx = r_depth[IW-1:0];
  assign w_pop_idx  = w_push_idx - IW'(1);
  assign w_pc_inc   = r_pc + AW'(1);

  always_comb begin
    w_pc_nxt      = r_pc;
    w_int_ret_nxt = r_int_ret;
    w_depth_nxt   = r_depth;
    w_isr_nxt     = r_isr;
    w_err_nxt     = r_err;
    w_push        = 1'b0;
    if (PCEN_i) begin
      if (int_i && !r_isr) begin
        w_int_ret_nxt = r_pc;
        w_pc_nxt      = INT_VEC;
        w_isr_nxt     = 1'b1;
      end else if (reti_i) begin
        if (r_isr) begin
          w_pc_nxt  = r_int_ret;
          w_isr_nxt = 1'b0;
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_err_nxt = 1'b1;
        end
      end else if (ret_i) begin
        if (!w_empty) begin
          w_pc_nxt    = r_stack[w_pop_idx];
          w_depth_nxt = r_depth - DW'(1);
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_err_nxt = 1'b1;
        end
      end else if (jbs_i) begin
        w_pc_nxt = target_i;
        if (!w_full) begin
          w_push      = 1'b1;
          w_depth_nxt = r_depth + DW'(1);
        end else begin
          w_err_nxt = 1'b1;
        end
      end else begin
        case (PCoper_i)
          4'b0100: w_pc_nxt = z_i  ? target_i : w_pc_inc;
          4'b0101: w_pc_nxt = !z_i ? target_i : w_pc_inc;
          4'b0110: w_pc_nxt = c_i  ? target_i : w_pc_inc;
          4'b0111: w_pc_nxt = !c_i ? target_i : w_pc_inc;
          4'b1000: w_pc_nxt = target_i;
          default: w_pc_nxt = w_pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RST_VEC;
      r_int_ret <= RST_VEC;
      r_depth   <= '0;
      r_isr     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_int_ret <= w_int_ret_nxt;
      r_depth   <= w_depth_nxt;
      r_isr     <= w_isr_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Stack contents need no reset: an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc_o        = r_pc;
  assign isr_o       = r_isr;
  assign stk_full_o  = w_full;
  assign stk_empty_o = w_empty;
  assign stk_err_o   = r_err;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// checked through an expected-value queue against a queue-based reference model.
module tb_pc_unit;

  localparam int AW = 12;
  localparam int W  = AW + 4;

  logic          clk;
  logic          rst;
  logic          PCEN_i;
  logic [3:0]    PCoper_i;
  logic          jbs_i, ret_i, reti_i, int_i;
  logic [AW-1:0] target_i;
  logic          z_i, c_i;
  logic [AW-1:0] pc_o;
  logic          isr_o, stk_full_o, stk_empty_o, stk_err_o;

  pc_unit dut (
    .clk(clk), .rst(rst), .PCEN_i(PCEN_i), .PCoper_i(PCoper_i),
    .jbs_i(jbs_i), .ret_i(ret_i), .reti_i(reti_i), .int_i(int_i),
    .target_i(target_i), .z_i(z_i), .c_i(c_i),
    .pc_o(pc_o), .isr_o(isr_o), .stk_full_o(stk_full_o),
    .stk_empty_o(stk_empty_o), .stk_err_o(stk_err_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int            m_pc;
  int            m_iret;
  int            m_stk[$];
  bit            m_isr;
  bit            m_err;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [W-1:0] model_vec();
    logic [AW-1:0] p;
    p = AW'(m_pc);
    return {p, m_isr, (m_stk.size() == 8), (m_stk.size() == 0), m_err};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {pc_o, isr_o, stk_full_o, stk_empty_o, stk_err_o};
  endfunction

  task automatic model_reset();
    m_pc   = 0;
    m_iret = 0;
    m_isr  = 0;
    m_err  = 0;
    m_stk.delete();
  endtask

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h isr=%b full=%b empty=%b err=%b, want pc=%h isr=%b full=%b empty=%b err=%b",
               name, act[W-1:4], act[3], act[2], act[1], act[0],
               exp[W-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: every clock edge carrying an issued request produces one output.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_vec(), e);
      end
    end
  end

  // Driver: apply one cycle of inputs, advance the model, queue the expectation.
  task automatic step(input bit en, input logic [3:0] op, input bit jbs, input bit ret,
                      input bit reti, input bit intr, input logic [AW-1:0] tgt,
                      input bit z, input bit c);
    int inc;
    bit take;
    @(negedge clk);
    PCEN_i = en; PCoper_i = op; jbs_i = jbs; ret_i = ret; reti_i = reti;
    int_i = intr; target_i = tgt; z_i = z; c_i = c;
    inc = (m_pc + 1) % 4096;
    if (en) begin
      if (intr && !m_isr) begin
        m_iret = m_pc;
        m_pc   = 4;
        m_isr  = 1;
      end else if (reti) begin
        if (m_isr) begin
          m_pc  = m_iret;
          m_isr = 0;
        end else begin
          m_pc  = inc;
          m_err = 1;
        end
      end else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = inc;
          m_err = 1;
        end
      end else if (jbs) begin
        if (m_stk.size() < 8) m_stk.push_back(inc);
        else m_err = 1;
        m_pc = int'(tgt);
      end else begin
        case (op)
          4'h4:    take = z;
          4'h5:    take = !z;
          4'h6:    take = c;
          4'h7:    take = !c;
          4'h8:    take = 1;
          default: take = 0;
        endcase
        m_pc = take ? int'(tgt) : inc;
      end
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic op_step(input logic [3:0] op, input logic [AW-1:0] tgt, input bit z, input bit c);
    step(1, op, 0, 0, 0, 0, tgt, z, c);
  endtask

  task automatic idle_inputs();
    PCEN_i = 0; PCoper_i = 0; jbs_i = 0; ret_i = 0; reti_i = 0;
    int_i = 0; target_i = 0; z_i = 0; c_i = 0;
  endtask

  // Assert reset between clock edges and check that it acts immediately.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    model_reset();
    compare(name, dut_vec(), model_vec());
    idle_inputs();
    @(negedge clk);
    compare({name, "_held"}, dut_vec(), model_vec());
    rst = 1;
  endtask

  initial begin
    int n;
    logic [3:0] op;
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset_state", dut_vec(), model_vec());
    rst = 1;

    // No update until the first enabled edge after reset release
    step(0, 4'h8, 0, 0, 0, 0, 12'h777, 0, 0);
    // Sequential count, then hold
    repeat (5) op_step(4'h0, 12'h000, 0, 0);
    repeat (3) step(0, 4'h8, 1, 1, 1, 1, 12'h3AB, 1, 1);

    // Branches
    op_step(4'h8, 12'h010, 0, 0);
    op_step(4'h4, 12'h080, 0, 0);
    op_step(4'h4, 12'h080, 1, 0);
    op_step(4'h7, 12'h080, 0, 0);
    op_step(4'h5, 12'h0F0, 1, 0);
    op_step(4'h6, 12'h0F0, 0, 1);
    op_step(4'h3, 12'h0F0, 1, 1);
    op_step(4'h8, 12'hFFF, 0, 0);
    op_step(4'h0, 12'h000, 0, 0);

    // Call / return
    op_step(4'h8, 12'h020, 0, 0);
    step(1, 4'h0, 1, 0, 0, 0, 12'h100, 0, 0);
    repeat (3) op_step(4'h0, 12'h000, 0, 0);
    step(1, 4'h0, 0, 1, 0, 0, 12'h000, 0, 0);

    // Overflow, reverse-order returns, underflow
    for (int i = 0; i < 9; i++) step(1, 4'h0, 1, 0, 0, 0, AW'(12'h200 + 16 * i), 0, 0);
    for (int i = 0; i < 9; i++) step(1, 4'h0, 0, 1, 0, 0, 12'h000, 0, 0);

    // Interrupts
    op_step(4'h8, 12'h050, 0, 0);
    step(1, 4'h0, 0, 0, 0, 1, 12'h000, 0, 0);
    step(1, 4'h0, 0, 0, 0, 1, 12'h000, 0, 0);
    step(1, 4'h0, 0, 0, 1, 0, 12'h000, 0, 0);
    step(1, 4'h0, 1, 0, 0, 1, 12'h300, 0, 0);
    step(1, 4'h0, 0, 0, 1, 0, 12'h000, 0, 0);
    step(1, 4'h0, 0, 0, 1, 0, 12'h000, 0, 0);
    // jbs with ret: only the return acts
    step(1, 4'h0, 1, 0, 0, 0, 12'h400, 0, 0);
    step(1, 4'h0, 1, 1, 0, 0, 12'h500, 0, 0);

    // Reset mid-call and mid-ISR
    pulse_reset("async_reset_1");
    repeat (3) step(1, 4'h0, 1, 0, 0, 0, 12'h600, 0, 0);
    step(1, 4'h0, 0, 0, 0, 1, 12'h000, 0, 0);
    op_step(4'h8, 12'h123, 0, 0);
    pulse_reset("async_reset_2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 9);
      case (n)
        0, 1, 2: op = 4'h0;
        3:       op = 4'h4;
        4:       op = 4'h5;
        5:       op = 4'h6;
        6:       op = 4'h7;
        7:       op = 4'h8;
        default: op = 4'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 9) != 0, op,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           AW'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i == 200) pulse_reset("async_reset_rand");
    end

    // Drain with a bounded wait
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
